// File: rtl/y86_pipe_reg.sv
// Stage register for the Y86 pipelined core: 1..4 slices of payload+valid with
// flush/bubble/stall control and saturating stall/bubble event counters.
module y86_pipe_reg #(
    parameter int               WIDTH   = 80,
    parameter logic [WIDTH-1:0] NOP_VAL = {WIDTH{1'b0}},
    parameter int               STAGES  = 1,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             bubble,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    if (STAGES < 1 || STAGES > 4 || WIDTH < 1 || WIDTH > 256) begin : g_param_err
        $error("y86_pipe_reg: STAGES must be 1..4 and WIDTH 1..256");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0]  pay_q [STAGES];
    logic [WIDTH-1:0]  pay_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;
    logic              stall_inc_s;
    logic              bubble_inc_s;

    // Clear wins over increment; the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        if (clr) begin
            res = CNT_ZERO;
        end else if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Slice next-state: flush > bubble > stall > normal advance.
    always_comb begin
        pay_d = pay_q;
        vld_d = vld_q;
        if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                pay_d[i] = NOP_VAL;
                vld_d[i] = 1'b0;
            end
        end else if (bubble) begin
            pay_d[0] = NOP_VAL;
            vld_d[0] = 1'b0;
            for (int i = 1; i < STAGES; i++) begin
                pay_d[i] = pay_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
        end else if (stall) begin
            pay_d = pay_q;
            vld_d = vld_q;
        end else begin
            pay_d[0] = din;
            vld_d[0] = din_valid;
            for (int i = 1; i < STAGES; i++) begin
                pay_d[i] = pay_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Counter next-state: a stall masked by bubble or flush is not counted as a stall.
    always_comb begin
        stall_inc_s  = stall & ~bubble & ~flush;
        bubble_inc_s = bubble & ~flush;
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_inc_s, clr_cnt);
        bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_inc_s, clr_cnt);
    end

    // State registers; reset also scrubs payload bits to the NOP encoding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i] <= NOP_VAL;
            end
            vld_q        <= {STAGES{1'b0}};
            stall_cnt_q  <= CNT_ZERO;
            bubble_cnt_q <= CNT_ZERO;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i] <= pay_d[i];
            end
            vld_q        <= vld_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign dout       = pay_q[STAGES-1];
    assign dout_valid = vld_q[STAGES-1];
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Bench for y86_pipe_reg: four configurations share one stimulus stream and are
// compared every cycle against a slice-list model, plus directed literal checks.
module tb_y86_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [79:0] din;
    logic        din_valid;
    logic        clr_cnt;
    logic        chk_en;

    logic [79:0] d0_dout;
    logic [19:0] d1_dout;
    logic [7:0]  d2_dout;
    logic [15:0] d3_dout;
    logic        d0_valid, d1_valid, d2_valid, d3_valid;
    logic [15:0] d0_sc, d0_bc, d1_sc, d1_bc, d2_sc, d2_bc;
    logic [2:0]  d3_sc, d3_bc;

    localparam logic [79:0] NOP0 = 80'h0000_0001_0000_0000_0010;

    y86_pipe_reg #(.WIDTH(80), .NOP_VAL(NOP0), .STAGES(1), .CNT_W(16)) u_d0 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .din(din), .din_valid(din_valid), .dout(d0_dout), .dout_valid(d0_valid),
        .clr_cnt(clr_cnt), .stall_cnt(d0_sc), .bubble_cnt(d0_bc));

    y86_pipe_reg #(.WIDTH(20), .NOP_VAL(20'h10000), .STAGES(2), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .din(din[19:0]), .din_valid(din_valid), .dout(d1_dout), .dout_valid(d1_valid),
        .clr_cnt(clr_cnt), .stall_cnt(d1_sc), .bubble_cnt(d1_bc));

    y86_pipe_reg #(.WIDTH(8), .NOP_VAL(8'h00), .STAGES(3), .CNT_W(16)) u_d2 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .din(din[7:0]), .din_valid(din_valid), .dout(d2_dout), .dout_valid(d2_valid),
        .clr_cnt(clr_cnt), .stall_cnt(d2_sc), .bubble_cnt(d2_bc));

    y86_pipe_reg #(.WIDTH(16), .NOP_VAL(16'hBEEF), .STAGES(4), .CNT_W(3)) u_d3 (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .din(din[15:0]), .din_valid(din_valid), .dout(d3_dout), .dout_valid(d3_valid),
        .clr_cnt(clr_cnt), .stall_cnt(d3_sc), .bubble_cnt(d3_bc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-configuration constants of the model.
    int          ns   [4] = '{1, 2, 3, 4};
    int          wd   [4] = '{80, 20, 8, 16};
    int          cmax [4] = '{65535, 65535, 65535, 7};
    logic [79:0] nops [4] = '{NOP0, 80'h10000, 80'h0, 80'hBEEF};

    // Model state: slice contents (index 0 nearest din) and counter values.
    logic [79:0] m_pay [4][4];
    logic        m_val [4][4];
    int          m_sc  [4];
    int          m_bc  [4];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [79:0] mask(input int w);
        logic [79:0] one;
        one = 80'd1;
        return (one << w) - one;
    endfunction

    task automatic chk(input string nm, input int k, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Model update from the spec's priority rules.
    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset) begin
                for (int i = 0; i < 4; i++) begin
                    m_pay[k][i] <= nops[k];
                    m_val[k][i] <= 1'b0;
                end
                m_sc[k] <= 0;
                m_bc[k] <= 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (i < ns[k]) begin
                        if (flush) begin
                            m_pay[k][i] <= nops[k];
                            m_val[k][i] <= 1'b0;
                        end else if (bubble || !stall) begin
                            if (i == 0) begin
                                m_pay[k][i] <= bubble ? nops[k] : (din & mask(wd[k]));
                                m_val[k][i] <= bubble ? 1'b0 : din_valid;
                            end else begin
                                m_pay[k][i] <= m_pay[k][i-1];
                                m_val[k][i] <= m_val[k][i-1];
                            end
                        end
                    end
                end
                if (clr_cnt) m_sc[k] <= 0;
                else if (stall && !bubble && !flush && m_sc[k] < cmax[k]) m_sc[k] <= m_sc[k] + 1;
                if (clr_cnt) m_bc[k] <= 0;
                else if (bubble && !flush && m_bc[k] < cmax[k]) m_bc[k] <= m_bc[k] + 1;
            end
        end
    end

    logic [79:0] o_pay [4];
    logic        o_val [4];
    logic [79:0] o_sc  [4];
    logic [79:0] o_bc  [4];
    assign o_pay[0] = d0_dout;             assign o_val[0] = d0_valid;
    assign o_pay[1] = {60'b0, d1_dout};    assign o_val[1] = d1_valid;
    assign o_pay[2] = {72'b0, d2_dout};    assign o_val[2] = d2_valid;
    assign o_pay[3] = {64'b0, d3_dout};    assign o_val[3] = d3_valid;
    assign o_sc[0] = {64'b0, d0_sc};       assign o_bc[0] = {64'b0, d0_bc};
    assign o_sc[1] = {64'b0, d1_sc};       assign o_bc[1] = {64'b0, d1_bc};
    assign o_sc[2] = {64'b0, d2_sc};       assign o_bc[2] = {64'b0, d2_bc};
    assign o_sc[3] = {77'b0, d3_sc};       assign o_bc[3] = {77'b0, d3_bc};

    // Every falling edge: all four instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk("dout", k, o_pay[k], m_pay[k][ns[k]-1]);
                chk("dout_valid", k, {79'b0, o_val[k]}, {79'b0, m_val[k][ns[k]-1]});
                chk("stall_cnt", k, o_sc[k], 80'(m_sc[k]));
                chk("bubble_cnt", k, o_bc[k], 80'(m_bc[k]));
            end
        end
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en = 1'b0;
        reset = 1'b1; stall = 1'b0; bubble = 1'b0; flush = 1'b0;
        din = 80'h0; din_valid = 1'b0; clr_cnt = 1'b0;
        #2 reset = 1'b0;
        #20;
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Reset: fill, then assert reset mid-cycle with ABCD on the input.
        din = 80'h12345; din_valid = 1'b1;
        edge_(); edge_();
        chk("pre_reset_dout", 1, {60'b0, d1_dout}, 80'h12345);
        din = 80'hABCD;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_dout", 1, {60'b0, d1_dout}, 80'h10000);
        chk("async_reset_valid", 1, {79'b0, d1_valid}, 80'h0);
        chk("async_reset_sc", 1, {64'b0, d1_sc}, 80'h0);
        chk("async_reset_bc", 1, {64'b0, d1_bc}, 80'h0);
        #2 reset = 1'b1;
        edge_(); edge_();
        chk("post_reset_dout", 1, {60'b0, d1_dout}, 80'hABCD);
        chk("post_reset_valid", 1, {79'b0, d1_valid}, 80'h1);

        // Stream 1,2,3,4 through 3 slices with a stall on the third edge.
        din = 80'd1; edge_();
        din = 80'd2; edge_();
        din = 80'd3; stall = 1'b1; edge_();
        chk("stream_e3", 2, {72'b0, d2_dout}, 80'hCD);
        stall = 1'b0; edge_();
        chk("stream_e4", 2, {72'b0, d2_dout}, 80'd1);
        din = 80'd4; edge_();
        chk("stream_e5", 2, {72'b0, d2_dout}, 80'd2);
        chk("stream_sc", 2, {64'b0, d2_sc}, 80'd1);

        // Bubble beats stall with s[0]=5, s[1]=4.
        din = 80'd5; edge_();
        chk("bub_pre", 1, {60'b0, d1_dout}, 80'd4);
        stall = 1'b1; bubble = 1'b1; edge_();
        chk("bub_dout", 1, {60'b0, d1_dout}, 80'd5);
        chk("bub_bc", 1, {64'b0, d1_bc}, 80'd1);
        chk("bub_sc", 1, {64'b0, d1_sc}, 80'd1);
        stall = 1'b0; bubble = 1'b0; din = 80'd6; edge_();
        chk("bub_nop", 1, {60'b0, d1_dout}, 80'h10000);
        chk("bub_nop_valid", 1, {79'b0, d1_valid}, 80'h0);

        // Flush outranks bubble and stall on a full 4-slice chain.
        for (int v = 7; v <= 10; v++) begin
            din = 80'(v); edge_();
        end
        chk("full_valid", 3, {79'b0, d3_valid}, 80'h1);
        chk("full_dout", 3, {64'b0, d3_dout}, 80'd7);
        flush = 1'b1; bubble = 1'b1; stall = 1'b1; edge_();
        chk("flush_dout", 3, {64'b0, d3_dout}, 80'hBEEF);
        chk("flush_valid", 3, {79'b0, d3_valid}, 80'h0);
        chk("flush_sc", 3, {77'b0, d3_sc}, 80'd1);
        chk("flush_bc", 3, {77'b0, d3_bc}, 80'd1);

        // Saturation of the 3-bit counter, then clear beating a stall.
        flush = 1'b0; bubble = 1'b0; stall = 1'b1;
        for (int c = 0; c < 10; c++) edge_();
        chk("sat_sc", 3, {77'b0, d3_sc}, 80'd7);
        chk("nosat_sc", 1, {64'b0, d1_sc}, 80'd11);
        clr_cnt = 1'b1; edge_();
        chk("clr_sc", 3, {77'b0, d3_sc}, 80'd0);
        chk("clr_bc", 3, {77'b0, d3_bc}, 80'd0);
        clr_cnt = 1'b0; stall = 1'b0;

        // Random traffic with rare flushes, clears and reset pulses.
        for (int n = 0; n < 1000; n++) begin
            stall     = ($urandom % 4) == 0;
            bubble    = ($urandom % 6) == 0;
            flush     = ($urandom % 25) == 0;
            clr_cnt   = ($urandom % 60) == 0;
            din_valid = $urandom % 2;
            din       = {16'($urandom), $urandom, $urandom};
            if (($urandom % 150) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            edge_();
        end
        stall = 1'b0; bubble = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
